ddr2_read_unload: RTL
=====================

# ddr2_read_unload

Read-return sequencer sitting directly downstream of the DDR2 8-deep read ring buffer, in the controller clock domain. For every read command issued by the command scheduler it:
- fires the one-cycle `listen` pulse into the ring buffer at the programmed read latency;
- waits for the strobe burst to land;
- steps the ring buffer's `readPtr` through 0..7;
- registers the eight 16-bit words onto a tagged, valid-qualified return stream for the host interface.

## Interface
Parameters:
- `RL`, 5: controller clocks from `rd_issue` to `listen` (CL+AL, in clk units); legal 2..15.
- `DRAIN`, 6: clocks from `listen` to first `readPtr` step (strobe burst plus settle margin); legal 4..8.
- `MIN_GAP`, 8: minimum clocks between accepted `rd_issue` pulses.
- `TAG_W`, 4: width of the read tag carried with each burst.

Ports:
- `clk`  in  1  controller clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_issue`  in  1  one-cycle pulse: read command issued to DRAM this cycle.
- `rd_tag`  in  TAG_W  tag for the read; sampled with `rd_issue`.
- `listen`  out  1  one-cycle pulse to the ring buffer `listen`.
- `readPtr`  out  3  ring buffer read pointer, registered.
- `din`  in  16  ring buffer `dout` (combinational from `readPtr`).
- `dout`  out  16  returned read word, registered.
- `dout_valid`  out  1  `dout` valid this cycle; no backpressure.
- `dout_last`  out  1  marks beat 7 of a burst.
- `dout_tag`  out  TAG_W  tag of the burst that `dout` belongs to.
- `busy`  out  1  any read in flight (delay line, drain or unload).
- `err_gap`  out  1  sticky: an `rd_issue` arrived inside `MIN_GAP`; cleared only by reset.

## Operation
- **Issue delay line:** an RL-stage shift register carries {valid, tag}.
  - Accepted `rd_issue` enters stage 0.
  - When it exits stage RL-1, `listen`=1 for exactly one cycle and {tag} transfers to the drain stage.
- **Gap check:** a counter reloads to MIN_GAP-1 on each accepted issue and decrements to 0.
  - An `rd_issue` seen while the counter is nonzero is dropped: no `listen`, no data.
  - A dropped issue sets `err_gap`.
- **Drain/unload FSM:** states IDLE, DRAIN, UNLOAD.
  - IDLE -> DRAIN on the `listen` cycle; the drain counter loads DRAIN-1.
  - DRAIN -> UNLOAD when the counter hits 0; `readPtr` is set to 0 on that transition.
  - UNLOAD: `readPtr` increments every cycle.
  - At `readPtr`=7: if a new `listen` fired this cycle, go to DRAIN; else go to IDLE. `readPtr` wraps to 0.
  - A `listen` arriving while in DRAIN or UNLOAD is legal only because MIN_GAP ≥ 8 ≥ DRAIN. The FSM holds one pending tag in a second register and enters DRAIN for it when the current unload ends, with the drain count preloaded so timing equals `listen`+DRAIN.
- **Data path:**
  - The cycle after `readPtr`=k is presented, `dout`←`din`, `dout_valid`=1 and `dout_tag`=burst tag.
  - `dout_last`=1 for k=7 only.
- **`busy`:** OR of any delay-line valid, FSM≠IDLE, pending tag valid and output-stage valid.
- **Reset** (async assert, sync release):
  - `listen`, `dout_valid`, `dout_last`, `busy` and `err_gap` go to 0.
  - `readPtr`=0, `dout`=0, `dout_tag`=0.
  - Delay line, gap counter and FSM clear to IDLE.
  - Reset mid-burst aborts the burst; no partial beats follow release.

## Timing
- `rd_issue` at cycle T -> `listen` at T+RL.
- `readPtr`=0 at T+RL+DRAIN, `readPtr`=7 at T+RL+DRAIN+7.
- `dout_valid` at T+RL+DRAIN+1 .. T+RL+DRAIN+8.
- `dout_last` at T+RL+DRAIN+8.
- Back-to-back issues at exactly MIN_GAP=8 produce a gapless stream of 16 valid beats.
- An issue in the same cycle the gap counter reaches 0 is accepted.
- `readPtr` holds its last value outside UNLOAD. It is 0 after reset.

## Test plan
- Single read, `rd_tag`=0x3, ring words 0xA000..0xA007 -> `listen` at T+5, `dout` 0xA000..0xA007 on T+12..T+19, `dout_last` only at T+19, `dout_tag`=0x3 throughout.
- Two reads at T and T+8, tags 1 and 2 -> 16 consecutive valid beats, tag switches 1->2 exactly at beat 8, `busy` falls at T+28.
- Issue at T and T+5 -> second dropped, `err_gap`=1 from T+6, only 8 beats out, one `listen`.
- Reset asserted at T+14 of a burst -> all outputs 0 immediately. After release, no further `dout_valid` and `busy`=0.
- Parameter sweep RL∈{2,15}, DRAIN∈{4,8} -> `listen`/`dout_valid` cycles match T+RL and T+RL+DRAIN+1 exactly.

Source files
------------

// File: rtl/ddr2_read_unload.sv
// rtl/ddr2_read_unload.sv - DDR2 read-return sequencer: listen timing, ring buffer unload, tagged return stream
module ddr2_read_unload #(
    parameter int RL      = 5,
    parameter int DRAIN   = 6,
    parameter int MIN_GAP = 8,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_issue,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             listen,
    output logic [2:0]       readPtr,
    input  logic [15:0]      din,
    output logic [15:0]      dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic [TAG_W-1:0] dout_tag,
    output logic             busy,
    output logic             err_gap
);
    localparam int         GAP_W    = $clog2(MIN_GAP) + 1;
    localparam logic [3:0] DRAIN_LD = 4'(DRAIN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_UNLOAD} state_t;

    logic [RL-1:0]    dl_valid_q;
    logic [TAG_W-1:0] dl_tag_q [RL];
    logic [GAP_W-1:0] gap_q;
    logic             err_q;
    logic             accept;
    logic [TAG_W-1:0] lst_tag;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       pcnt_q, pcnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
    logic [TAG_W-1:0] pend_tag_q, pend_tag_d;
    logic             pend_q, pend_d;

    logic [15:0]      dout_q;
    logic             dvalid_q, dlast_q;
    logic [TAG_W-1:0] dtag_q;

    assign accept  = rd_issue && (gap_q == '0);
    assign listen  = dl_valid_q[RL-1];
    assign lst_tag = dl_tag_q[RL-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_valid_q <= '0;
            for (int i = 0; i < RL; i++) dl_tag_q[i] <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            dl_valid_q  <= {dl_valid_q[RL-2:0], accept};
            dl_tag_q[0] <= rd_tag;
            for (int i = 1; i < RL; i++) dl_tag_q[i] <= dl_tag_q[i-1];
            if (accept)
                gap_q <= GAP_W'(MIN_GAP - 1);
            else if (gap_q != '0)
                gap_q <= gap_q - GAP_W'(1);
            if (rd_issue && !accept)
                err_q <= 1'b1;
        end
    end

    // A listen that lands mid-unload is parked with its own countdown so its
    // unload starts exactly DRAIN clocks after its listen, even back-to-back.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        cur_tag_d  = cur_tag_q;
        pend_d     = pend_q;
        pend_tag_d = pend_tag_q;
        pcnt_d     = pcnt_q;
        if (pend_q && pcnt_q != 4'd0)
            pcnt_d = pcnt_q - 4'd1;
        case (state_q)
            S_IDLE: begin
                if (listen) begin
                    state_d   = S_DRAIN;
                    cnt_d     = DRAIN_LD;
                    cur_tag_d = lst_tag;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_UNLOAD;
                    ptr_d   = 3'd0;
                end
                if (listen) begin
                    pend_d     = 1'b1;
                    pend_tag_d = lst_tag;
                    pcnt_d     = DRAIN_LD;
                end
            end
            S_UNLOAD: begin
                ptr_d = ptr_q + 3'd1;
                if (ptr_q == 3'd7) begin
                    if (listen) begin
                        state_d   = S_DRAIN;
                        cnt_d     = DRAIN_LD;
                        cur_tag_d = lst_tag;
                    end else if (pend_q) begin
                        pend_d    = 1'b0;
                        cur_tag_d = pend_tag_q;
                        if (pcnt_q <= 4'd1) begin
                            state_d = S_UNLOAD;
                        end else begin
                            state_d = S_DRAIN;
                            cnt_d   = pcnt_q - 4'd1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (listen) begin
                    pend_d     = 1'b1;
                    pend_tag_d = lst_tag;
                    pcnt_d     = DRAIN_LD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pcnt_q     <= '0;
            ptr_q      <= '0;
            cur_tag_q  <= '0;
            pend_tag_q <= '0;
            pend_q     <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            dlast_q    <= 1'b0;
            dtag_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            ptr_q      <= ptr_d;
            cur_tag_q  <= cur_tag_d;
            pend_tag_q <= pend_tag_d;
            pend_q     <= pend_d;
            if (state_q == S_UNLOAD) begin
                dout_q   <= din;
                dvalid_q <= 1'b1;
                dlast_q  <= (ptr_q == 3'd7);
                dtag_q   <= cur_tag_q;
            end else begin
                dvalid_q <= 1'b0;
                dlast_q  <= 1'b0;
            end
        end
    end

    assign readPtr    = ptr_q;
    assign dout       = dout_q;
    assign dout_valid = dvalid_q;
    assign dout_last  = dlast_q;
    assign dout_tag   = dtag_q;
    assign err_gap    = err_q;
    assign busy       = (|dl_valid_q) || (state_q != S_IDLE) || pend_q || dvalid_q;

endmodule
